// File: rtl/race_ctl.sv
// Race sequencer: start countdown, control gating, lap counting and penalty
// handling, all paced by an internal tick divider. Every output is registered.
module race_ctl #(
    parameter int TICK_CYCLES = 65_000_000,
    parameter int COUNTDOWN_S = 3,
    parameter int LAPS        = 3,
    parameter int MSG_HOLD_S  = 2
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       lap_finished,
    input  logic       checkpoints_passed,
    input  logic       max_time_exceeded,
    input  logic [3:0] controls_in,
    output logic [3:0] controls_out,
    output logic       timer_start,
    output logic       timer_reset,
    output logic       countdown_visible,
    output logic [1:0] countdown_digit,
    output logic       go_visible,
    output logic       too_slow_visible,
    output logic       cheater_visible,
    output logic [2:0] lap_count,
    output logic       race_done
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [1:0]    CD_START  = 2'(COUNTDOWN_S);
    localparam logic [2:0]    LAPS_W    = 3'(LAPS);
    localparam logic [3:0]    HOLD_LAST = 4'(MSG_HOLD_S - 1);

    typedef enum logic [2:0] {IDLE, COUNTDOWN, RACE, PENALTY, FINISH} state_t;

    state_t        state, state_next;
    logic [CW-1:0] tick_cnt, tick_cnt_next;
    logic          tick;
    logic [3:0]    msg_cnt, msg_cnt_next;
    logic [2:0]    lap_inc;

    logic [3:0] controls_out_next;
    logic       timer_start_next, timer_reset_next, countdown_visible_next;
    logic [1:0] countdown_digit_next;
    logic       go_visible_next, too_slow_visible_next, cheater_visible_next;
    logic [2:0] lap_count_next;
    logic       race_done_next;

    always_comb tick = (tick_cnt == TICK_LAST);
    always_comb lap_inc = lap_count + 3'd1;

    always_comb begin
        state_next             = state;
        msg_cnt_next           = msg_cnt;
        timer_reset_next       = 1'b0;
        countdown_visible_next = countdown_visible;
        countdown_digit_next   = countdown_digit;
        go_visible_next        = go_visible;
        too_slow_visible_next  = too_slow_visible;
        cheater_visible_next   = cheater_visible;
        lap_count_next         = lap_count;
        race_done_next         = race_done;

        case (state)
            IDLE: begin
                lap_count_next = '0;
                if (start) begin
                    state_next             = COUNTDOWN;
                    countdown_digit_next   = CD_START;
                    countdown_visible_next = 1'b1;
                    timer_reset_next       = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (countdown_digit > 2'd1) begin
                        countdown_digit_next = countdown_digit - 2'd1;
                    end else begin
                        state_next             = RACE;
                        countdown_visible_next = 1'b0;
                        go_visible_next        = 1'b1;
                        timer_reset_next       = 1'b1;
                    end
                end
            end
            RACE: begin
                if (tick) go_visible_next = 1'b0;
                // Valid lap outranks cheater, which outranks too slow.
                if (lap_finished && checkpoints_passed) begin
                    lap_count_next   = lap_inc;
                    timer_reset_next = 1'b1;
                    if (lap_inc == LAPS_W) begin
                        state_next      = FINISH;
                        race_done_next  = 1'b1;
                        go_visible_next = 1'b0;
                    end
                end else if (lap_finished) begin
                    state_next           = PENALTY;
                    cheater_visible_next = 1'b1;
                    go_visible_next      = 1'b0;
                end else if (max_time_exceeded) begin
                    state_next            = PENALTY;
                    too_slow_visible_next = 1'b1;
                    go_visible_next       = 1'b0;
                end
            end
            PENALTY: begin
                if (tick) begin
                    if (msg_cnt == HOLD_LAST) begin
                        state_next             = COUNTDOWN;
                        too_slow_visible_next  = 1'b0;
                        cheater_visible_next   = 1'b0;
                        countdown_digit_next   = CD_START;
                        countdown_visible_next = 1'b1;
                        timer_reset_next       = 1'b1;
                    end else begin
                        msg_cnt_next = msg_cnt + 4'd1;
                    end
                end
            end
            FINISH: begin
            end
            default: state_next = IDLE;
        endcase

        if (!start) begin
            state_next             = IDLE;
            timer_reset_next       = 1'b0;
            countdown_visible_next = 1'b0;
            countdown_digit_next   = '0;
            go_visible_next        = 1'b0;
            too_slow_visible_next  = 1'b0;
            cheater_visible_next   = 1'b0;
            lap_count_next         = '0;
            race_done_next         = 1'b0;
        end

        if (state_next != PENALTY) msg_cnt_next = '0;

        controls_out_next = (state_next == RACE) ? controls_in : '0;
        timer_start_next  = (state_next == RACE);
        // The divider restarts on any state change so each state's first tick is a full period away.
        tick_cnt_next = (state_next != state || tick) ? '0 : tick_cnt + CW'(1);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            tick_cnt          <= '0;
            msg_cnt           <= '0;
            controls_out      <= '0;
            timer_start       <= 1'b0;
            timer_reset       <= 1'b0;
            countdown_visible <= 1'b0;
            countdown_digit   <= '0;
            go_visible        <= 1'b0;
            too_slow_visible  <= 1'b0;
            cheater_visible   <= 1'b0;
            lap_count         <= '0;
            race_done         <= 1'b0;
        end else begin
            state             <= state_next;
            tick_cnt          <= tick_cnt_next;
            msg_cnt           <= msg_cnt_next;
            controls_out      <= controls_out_next;
            timer_start       <= timer_start_next;
            timer_reset       <= timer_reset_next;
            countdown_visible <= countdown_visible_next;
            countdown_digit   <= countdown_digit_next;
            go_visible        <= go_visible_next;
            too_slow_visible  <= too_slow_visible_next;
            cheater_visible   <= cheater_visible_next;
            lap_count         <= lap_count_next;
            race_done         <= race_done_next;
        end
    end

endmodule

// File: tb/tb_race_ctl.sv
// Bench for race_ctl: directed race scenarios followed by random traffic,
// checked every cycle against a phase/elapsed-time model of the race rules.
module tb_race_ctl;

    localparam int T    = 10;
    localparam int CD   = 3;
    localparam int NLAP = 3;
    localparam int HOLD = 2;

    localparam int P_IDLE = 0, P_CD = 1, P_RACE = 2, P_PEN = 3, P_FIN = 4;

    logic       pclk = 1'b0;
    logic       rst, start, lap_finished, checkpoints_passed, max_time_exceeded;
    logic [3:0] controls_in;
    logic [3:0] controls_out;
    logic       timer_start, timer_reset, countdown_visible, go_visible;
    logic       too_slow_visible, cheater_visible, race_done;
    logic [1:0] countdown_digit;
    logic [2:0] lap_count;

    int checks   = 0;
    int failures = 0;

    race_ctl #(.TICK_CYCLES(T), .COUNTDOWN_S(CD), .LAPS(NLAP), .MSG_HOLD_S(HOLD)) dut (
        .pclk(pclk), .rst(rst), .start(start), .lap_finished(lap_finished),
        .checkpoints_passed(checkpoints_passed), .max_time_exceeded(max_time_exceeded),
        .controls_in(controls_in), .controls_out(controls_out), .timer_start(timer_start),
        .timer_reset(timer_reset), .countdown_visible(countdown_visible),
        .countdown_digit(countdown_digit), .go_visible(go_visible),
        .too_slow_visible(too_slow_visible), .cheater_visible(cheater_visible),
        .lap_count(lap_count), .race_done(race_done)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase, cycles elapsed in that phase, laps, message kind.
    int         m_phase, m_age, m_laps, m_msg;
    logic       m_tr;
    logic [3:0] m_ctl;

    always @(posedge pclk or negedge rst) begin : model
        int ph, age, laps, msg;
        logic tr;
        if (!rst) begin
            m_phase <= P_IDLE; m_age <= 0; m_laps <= 0; m_msg <= 0; m_tr <= 1'b0; m_ctl <= '0;
        end else begin
            ph = m_phase; age = m_age; laps = m_laps; msg = m_msg; tr = 1'b0;
            if (!start) begin
                ph = P_IDLE; laps = 0; msg = 0;
            end else begin
                case (m_phase)
                    P_IDLE: begin ph = P_CD; tr = 1'b1; end
                    P_CD: if (age == CD * T - 1) begin ph = P_RACE; tr = 1'b1; end
                    P_RACE: begin
                        if (lap_finished && checkpoints_passed) begin
                            laps = laps + 1; tr = 1'b1;
                            if (laps == NLAP) ph = P_FIN;
                        end else if (lap_finished) begin
                            ph = P_PEN; msg = 1;
                        end else if (max_time_exceeded) begin
                            ph = P_PEN; msg = 2;
                        end
                    end
                    P_PEN: if (age == HOLD * T - 1) begin ph = P_CD; msg = 0; tr = 1'b1; end
                    default: ;
                endcase
            end
            m_age   <= (ph != m_phase) ? 0 : age + 1;
            m_phase <= ph;
            m_laps  <= laps;
            m_msg   <= msg;
            m_tr    <= tr;
            m_ctl   <= (ph == P_RACE) ? controls_in : 4'h0;
        end
    end

    always @(negedge pclk) begin
        check("controls_out", 32'(controls_out), 32'(m_ctl));
        check("timer_start", 32'(timer_start), 32'(m_phase == P_RACE));
        check("timer_reset", 32'(timer_reset), 32'(m_tr));
        check("countdown_visible", 32'(countdown_visible), 32'(m_phase == P_CD));
        if (m_phase == P_CD) check("countdown_digit", 32'(countdown_digit), 32'(CD - m_age / T));
        if (m_phase == P_IDLE) check("digit_idle", 32'(countdown_digit), 32'd0);
        check("go_visible", 32'(go_visible), 32'(m_phase == P_RACE && m_age < T));
        check("cheater_visible", 32'(cheater_visible), 32'(m_msg == 1));
        check("too_slow_visible", 32'(too_slow_visible), 32'(m_msg == 2));
        check("lap_count", 32'(lap_count), 32'(m_laps));
        check("race_done", 32'(race_done), 32'(m_phase == P_FIN));
    end

    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (m_phase != p && n < budget) begin
            cycle();
            n++;
        end
        check("wait_phase_timeout", 32'(m_phase), 32'(p));
    endtask

    task automatic pulse_lap(input logic cp, input logic mte);
        lap_finished = 1'b1; checkpoints_passed = cp; max_time_exceeded = mte;
        cycle();
        lap_finished = 1'b0; checkpoints_passed = 1'b0; max_time_exceeded = 1'b0;
        repeat (4) cycle();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; lap_finished = 1'b0; checkpoints_passed = 1'b0;
        max_time_exceeded = 1'b0; controls_in = 4'b1010;
        repeat (3) cycle();
        rst = 1'b1;
        start = 1'b1;
        wait_phase(P_RACE, 50);
        repeat (15) cycle();
        pulse_lap(1'b1, 1'b0);
        pulse_lap(1'b1, 1'b0);
        pulse_lap(1'b1, 1'b0);
        pulse_lap(1'b1, 1'b0);
        check("finish_laps", 32'(lap_count), 32'(NLAP));

        start = 1'b0; cycle(); start = 1'b1;
        wait_phase(P_RACE, 50);
        pulse_lap(1'b1, 1'b0);
        pulse_lap(1'b0, 1'b0);
        wait_phase(P_CD, 40);
        wait_phase(P_RACE, 50);
        pulse_lap(1'b1, 1'b1);
        check("coincide_no_slow", 32'(too_slow_visible), 32'd0);
        max_time_exceeded = 1'b1; cycle(); max_time_exceeded = 1'b0;
        repeat (5) cycle();
        check("slow_shown", 32'(too_slow_visible), 32'd1);
        start = 1'b0; cycle(); start = 1'b1;
        wait_phase(P_CD, 5);
        repeat (7) cycle();

        #2 rst = 1'b0;
        #1;
        check("async_rst_vis", 32'(countdown_visible), 32'd0);
        check("async_rst_tr", 32'({controls_out, timer_start, timer_reset, countdown_digit,
                                   go_visible, lap_count, race_done}), 32'd0);
        cycle();
        rst = 1'b1;
        wait_phase(P_RACE, 50);

        for (int i = 0; i < 3000; i++) begin
            start              = ($urandom_range(0, 299) != 0);
            lap_finished       = ($urandom_range(0, 15) == 0);
            checkpoints_passed = ($urandom_range(0, 3) != 0);
            max_time_exceeded  = ($urandom_range(0, 24) == 0);
            controls_in        = 4'($urandom);
            cycle();
        end
        start = 1'b0;
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
